// File: rtl/sd_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// sd_access_arbiter_if
// Bundle of every signal between the SD access arbiter, its two block-transfer
// requesters and the single SD card controller. Signal names follow the
// controller's native protocol so the SD side can be wired straight through.
//
//   requester side (N = 0,1)
//     reqN_Enable, reqN_Addr_Block, reqN_SerialCount, reqN_InPut_Data   -> arbiter
//     reqN_Complite, reqN_Fail, reqN_Out_Data_Valid,
//     reqN_InPut_Data_Valid                                             <- arbiter
//     req_Out_Data, req_Out_Data_Addr, req_InPut_Data_Addr (broadcast)  <- arbiter
//   controller side
//     SD_Init_Complite, SD_Complite, SD_Fail, SD_Out_Data_Valid,
//     SD_Out_Data_Addr, SD_Out_Data, SD_InPut_Data_Valid,
//     SD_InPut_Data_Addr                                                -> arbiter
//     SD_Enable, SD_Addr_Block, SD_SerialCount, SD_InPut_Data           <- arbiter
//
// Modports
//   slave  : the arbiter
//   master : the environment (requesters + controller) driving the arbiter
// ---------------------------------------------------------------------------
interface sd_access_arbiter_if;
   // requester 0
   logic        req0_Enable;
   logic [31:0] req0_Addr_Block;
   logic [31:0] req0_SerialCount;
   logic [31:0] req0_InPut_Data;
   logic        req0_Complite;
   logic        req0_Fail;
   logic        req0_Out_Data_Valid;
   logic        req0_InPut_Data_Valid;
   // requester 1
   logic        req1_Enable;
   logic [31:0] req1_Addr_Block;
   logic [31:0] req1_SerialCount;
   logic [31:0] req1_InPut_Data;
   logic        req1_Complite;
   logic        req1_Fail;
   logic        req1_Out_Data_Valid;
   logic        req1_InPut_Data_Valid;
   // broadcast to both requesters
   logic [31:0] req_Out_Data;
   logic [31:0] req_Out_Data_Addr;
   logic [31:0] req_InPut_Data_Addr;
   // SD controller
   logic        SD_Init_Complite;
   logic        SD_Enable;
   logic [31:0] SD_Addr_Block;
   logic [31:0] SD_SerialCount;
   logic        SD_Complite;
   logic        SD_Fail;
   logic        SD_Out_Data_Valid;
   logic [31:0] SD_Out_Data_Addr;
   logic [31:0] SD_Out_Data;
   logic        SD_InPut_Data_Valid;
   logic [31:0] SD_InPut_Data_Addr;
   logic [31:0] SD_InPut_Data;

   modport slave (
      input  req0_Enable, req0_Addr_Block, req0_SerialCount, req0_InPut_Data,
      output req0_Complite, req0_Fail, req0_Out_Data_Valid, req0_InPut_Data_Valid,
      input  req1_Enable, req1_Addr_Block, req1_SerialCount, req1_InPut_Data,
      output req1_Complite, req1_Fail, req1_Out_Data_Valid, req1_InPut_Data_Valid,
      output req_Out_Data, req_Out_Data_Addr, req_InPut_Data_Addr,
      input  SD_Init_Complite,
      output SD_Enable, SD_Addr_Block, SD_SerialCount,
      input  SD_Complite, SD_Fail,
      input  SD_Out_Data_Valid, SD_Out_Data_Addr, SD_Out_Data,
      input  SD_InPut_Data_Valid, SD_InPut_Data_Addr,
      output SD_InPut_Data
   );

   modport master (
      output req0_Enable, req0_Addr_Block, req0_SerialCount, req0_InPut_Data,
      input  req0_Complite, req0_Fail, req0_Out_Data_Valid, req0_InPut_Data_Valid,
      output req1_Enable, req1_Addr_Block, req1_SerialCount, req1_InPut_Data,
      input  req1_Complite, req1_Fail, req1_Out_Data_Valid, req1_InPut_Data_Valid,
      input  req_Out_Data, req_Out_Data_Addr, req_InPut_Data_Addr,
      output SD_Init_Complite,
      input  SD_Enable, SD_Addr_Block, SD_SerialCount,
      output SD_Complite, SD_Fail,
      output SD_Out_Data_Valid, SD_Out_Data_Addr, SD_Out_Data,
      output SD_InPut_Data_Valid, SD_InPut_Data_Addr,
      input  SD_InPut_Data
   );
endinterface

// File: rtl/sd_access_arbiter.sv
// ---------------------------------------------------------------------------
// sd_access_arbiter
// Shares one SD card controller between two block-transfer requesters
// (req0 = BMP copier, req1 = second client). Whole transactions are granted;
// address and block count are captured at grant, data strobes and the
// Complite/Fail status reach only the owner. A watchdog turns a hung
// controller transaction into a Fail.
//
// Ports
//   clk     in  system clock
//   rst     in  asynchronous reset, active low
//   io_bus  sd_access_arbiter_if.slave - requester and controller signals
//
// Parameters
//   TIMEOUT_CYCLES  maximum cycles spent in GRANT before a forced Fail;
//                   0 disables the watchdog
// ---------------------------------------------------------------------------
module sd_access_arbiter #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   sd_access_arbiter_if.slave    io_bus
);

   // state   | meaning
   // --------+-------------------------------------------------------------
   // IDLE    | controller released; arbitrate among raised Enables
   // GRANT   | owner's transaction running, SD_Enable high, watchdog counting
   // RELEASE | owner sees Complite/Fail; wait for owner and controller to
   //         | drop Enable/status before arbitrating again
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_owner;
   logic        r_prio;
   logic        r_sd_enable;
   logic [31:0] r_addr_block;
   logic [31:0] r_serial_count;
   logic [1:0]  r_complite;
   logic [1:0]  r_fail;
   logic [31:0] r_timer;

   logic [1:0]  w_en;
   logic        w_pick;
   logic        w_owner_en;
   logic        w_timeout;
   logic        w_sd_status;

   logic        w_req0_out_valid;
   logic        w_req1_out_valid;
   logic        w_req0_in_valid;
   logic        w_req1_in_valid;
   logic [31:0] w_sd_input_data;

   assign w_en        = {io_bus.req1_Enable, io_bus.req0_Enable};
   // with both requesting the priority pointer decides, otherwise the lone requester wins
   assign w_pick      = (w_en == 2'b11) ? r_prio : w_en[1];
   assign w_owner_en  = r_owner ? io_bus.req1_Enable : io_bus.req0_Enable;
   assign w_timeout   = (TIMEOUT_CYCLES != 32'd0) &&
                        (r_timer == (TIMEOUT_CYCLES - 32'd1));
   assign w_sd_status = io_bus.SD_Complite | io_bus.SD_Fail;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= ST_IDLE;
         r_owner        <= 1'b0;
         r_prio         <= 1'b0;
         r_sd_enable    <= 1'b0;
         r_addr_block   <= 32'd0;
         r_serial_count <= 32'd0;
         r_complite     <= 2'b00;
         r_fail         <= 2'b00;
         r_timer        <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_sd_enable <= 1'b0;
               if (io_bus.SD_Init_Complite && (w_en != 2'b00)) begin
                  r_owner        <= w_pick;
                  r_addr_block   <= w_pick ? io_bus.req1_Addr_Block  : io_bus.req0_Addr_Block;
                  r_serial_count <= w_pick ? io_bus.req1_SerialCount : io_bus.req0_SerialCount;
                  r_timer        <= 32'd0;
                  r_sd_enable    <= 1'b1;
                  r_state        <= ST_GRANT;
               end
            end

            ST_GRANT: begin
               r_timer <= r_timer + 32'd1;
               if (io_bus.SD_Complite) begin
                  r_complite[r_owner] <= 1'b1;
                  r_prio              <= ~r_owner;
                  r_sd_enable         <= 1'b0;
                  r_state             <= ST_RELEASE;
               end else if (io_bus.SD_Fail || !io_bus.SD_Init_Complite || w_timeout) begin
                  // keep priority with the failing owner so its retry is not interleaved
                  r_fail[r_owner] <= 1'b1;
                  r_prio          <= r_owner;
                  r_sd_enable     <= 1'b0;
                  r_state         <= ST_RELEASE;
               end else if (!w_owner_en) begin
                  // abort: owner withdrew, release silently
                  r_prio      <= ~r_owner;
                  r_sd_enable <= 1'b0;
                  r_state     <= ST_RELEASE;
               end
            end

            ST_RELEASE: begin
               r_sd_enable <= 1'b0;
               if (!w_owner_en && !w_sd_status) begin
                  r_complite <= 2'b00;
                  r_fail     <= 2'b00;
                  r_timer    <= 32'd0;
                  r_state    <= ST_IDLE;
               end
            end

            default: begin
               r_sd_enable <= 1'b0;
               r_complite  <= 2'b00;
               r_fail      <= 2'b00;
               r_timer     <= 32'd0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   // Data strobes follow the controller in the same cycle, but only to the owner and only in GRANT.
   always_comb begin
      w_req0_out_valid = 1'b0;
      w_req1_out_valid = 1'b0;
      w_req0_in_valid  = 1'b0;
      w_req1_in_valid  = 1'b0;
      w_sd_input_data  = 32'd0;
      if (r_state == ST_GRANT) begin
         if (r_owner) begin
            w_req1_out_valid = io_bus.SD_Out_Data_Valid;
            w_req1_in_valid  = io_bus.SD_InPut_Data_Valid;
            w_sd_input_data  = io_bus.req1_InPut_Data;
         end else begin
            w_req0_out_valid = io_bus.SD_Out_Data_Valid;
            w_req0_in_valid  = io_bus.SD_InPut_Data_Valid;
            w_sd_input_data  = io_bus.req0_InPut_Data;
         end
      end
   end

   assign io_bus.SD_Enable             = r_sd_enable;
   assign io_bus.SD_Addr_Block         = r_addr_block;
   assign io_bus.SD_SerialCount        = r_serial_count;
   assign io_bus.SD_InPut_Data         = w_sd_input_data;

   assign io_bus.req0_Complite         = r_complite[0];
   assign io_bus.req1_Complite         = r_complite[1];
   assign io_bus.req0_Fail             = r_fail[0];
   assign io_bus.req1_Fail             = r_fail[1];

   assign io_bus.req0_Out_Data_Valid   = w_req0_out_valid;
   assign io_bus.req1_Out_Data_Valid   = w_req1_out_valid;
   assign io_bus.req0_InPut_Data_Valid = w_req0_in_valid;
   assign io_bus.req1_InPut_Data_Valid = w_req1_in_valid;

   // read data and both word addresses are shared; only the strobes select the receiver
   assign io_bus.req_Out_Data          = io_bus.SD_Out_Data;
   assign io_bus.req_Out_Data_Addr     = io_bus.SD_Out_Data_Addr;
   assign io_bus.req_InPut_Data_Addr   = io_bus.SD_InPut_Data_Addr;

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Scoreboard bench for sd_access_arbiter: stimulus pushes expected events
// (grant, enable drop, owner status, data strobes) with their cycle stamps;
// a negedge monitor turns DUT activity into events and pops/compares them.
module tb_sd_access_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sd_access_arbiter_if bus();

   sd_access_arbiter #(.TIMEOUT_CYCLES(32'd100)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   localparam int K_GRANT = 0;
   localparam int K_DROP  = 1;
   localparam int K_DONE  = 2;
   localparam int K_FAIL  = 3;
   localparam int K_WR    = 4;
   localparam int K_RD    = 5;

   typedef struct {
      int          kind;
      int          who;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
   } ev_t;

   ev_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;
   int  cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(int k);
      case (k)
         K_GRANT: return "grant";
         K_DROP:  return "drop";
         K_DONE:  return "complite";
         K_FAIL:  return "fail";
         K_WR:    return "wr_strobe";
         K_RD:    return "rd_strobe";
         default: return "unknown";
      endcase
   endfunction

   task automatic push(int k, int w, logic [31:0] a, logic [31:0] b, int c);
      ev_t e;
      e.kind = k; e.who = w; e.a = a; e.b = b; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic compare_ev(ev_t got);
      ev_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_%s: got who=%0d a=%h b=%h cyc=%0d, required no event",
                  kname(got.kind), got.who, got.a, got.b, got.cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != got.kind || e.who != got.who || e.a != got.a ||
             e.b != got.b || e.cyc != got.cyc) begin
            n_err++;
            $display("FAIL event_%s: got %s who=%0d a=%h b=%h cyc=%0d, required %s who=%0d a=%h b=%h cyc=%0d",
                     kname(e.kind), kname(got.kind), got.who, got.a, got.b, got.cyc,
                     kname(e.kind), e.who, e.a, e.b, e.cyc);
         end
      end
   endtask

   task automatic check(string name, logic [31:0] got, logic [31:0] req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   // monitor
   logic p_en = 1'b0, p_c0 = 1'b0, p_f0 = 1'b0, p_c1 = 1'b0, p_f1 = 1'b0;
   always @(negedge clk) begin
      ev_t g;
      g.cyc = cyc;
      g.who = 0;
      g.a   = 32'd0;
      g.b   = 32'd0;
      if (bus.SD_Enable && !p_en) begin
         g.kind = K_GRANT; g.a = bus.SD_Addr_Block; g.b = bus.SD_SerialCount; compare_ev(g);
      end
      if (!bus.SD_Enable && p_en) begin
         g.kind = K_DROP; g.a = bus.SD_Addr_Block; g.b = bus.SD_SerialCount; compare_ev(g);
      end
      g.a = 32'd0; g.b = 32'd0;
      if (bus.req0_Complite && !p_c0) begin g.kind = K_DONE; g.who = 0; compare_ev(g); end
      if (bus.req0_Fail && !p_f0)     begin g.kind = K_FAIL; g.who = 0; compare_ev(g); end
      if (bus.req1_Complite && !p_c1) begin g.kind = K_DONE; g.who = 1; compare_ev(g); end
      if (bus.req1_Fail && !p_f1)     begin g.kind = K_FAIL; g.who = 1; compare_ev(g); end
      if (bus.SD_InPut_Data_Valid) begin
         g.kind = K_WR;
         g.who  = {30'd0, bus.req1_InPut_Data_Valid, bus.req0_InPut_Data_Valid};
         g.a    = bus.SD_InPut_Data;
         g.b    = bus.req_InPut_Data_Addr;
         compare_ev(g);
      end
      if (bus.SD_Out_Data_Valid) begin
         g.kind = K_RD;
         g.who  = {30'd0, bus.req1_Out_Data_Valid, bus.req0_Out_Data_Valid};
         g.a    = bus.req_Out_Data;
         g.b    = bus.req_Out_Data_Addr;
         compare_ev(g);
      end
      p_en = bus.SD_Enable;
      p_c0 = bus.req0_Complite; p_f0 = bus.req0_Fail;
      p_c1 = bus.req1_Complite; p_f1 = bus.req1_Fail;
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_en(int id, logic en);
      if (id == 0) bus.req0_Enable = en;
      else         bus.req1_Enable = en;
   endtask

   task automatic set_req(int id, logic en, logic [31:0] a, logic [31:0] c);
      if (id == 0) begin
         bus.req0_Addr_Block = a; bus.req0_SerialCount = c;
      end else begin
         bus.req1_Addr_Block = a; bus.req1_SerialCount = c;
      end
      set_en(id, en);
   endtask

   // controller status now; drop + owner status next edge; release exits the edge after
   task automatic finish_txn(int id, logic [31:0] a, logic [31:0] c, int kind);
      if (kind == K_DONE) bus.SD_Complite = 1'b1;
      else                bus.SD_Fail     = 1'b1;
      push(K_DROP, 0, a, c, cyc + 1);
      push(kind, id, 32'd0, 32'd0, cyc + 1);
      step(1);
      bus.SD_Complite = 1'b0;
      bus.SD_Fail     = 1'b0;
      set_en(id, 1'b0);
      step(1);
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_sd_enable"},   {31'd0, bus.SD_Enable}, 32'd0);
      check({tag, "_sd_addr"},     bus.SD_Addr_Block, 32'd0);
      check({tag, "_sd_count"},    bus.SD_SerialCount, 32'd0);
      check({tag, "_status"},      {28'd0, bus.req1_Fail, bus.req1_Complite,
                                    bus.req0_Fail, bus.req0_Complite}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL sim_time_limit: got no end of stimulus, required finish before 200000");
      $fatal(1, "time limit");
   end

   initial begin
      int g;
      ev_t e;
      bus.req0_Enable = 1'b0; bus.req0_Addr_Block = '0; bus.req0_SerialCount = '0; bus.req0_InPut_Data = '0;
      bus.req1_Enable = 1'b0; bus.req1_Addr_Block = '0; bus.req1_SerialCount = '0; bus.req1_InPut_Data = '0;
      bus.SD_Init_Complite = 1'b1; bus.SD_Complite = 1'b0; bus.SD_Fail = 1'b0;
      bus.SD_Out_Data_Valid = 1'b0; bus.SD_Out_Data_Addr = '0; bus.SD_Out_Data = '0;
      bus.SD_InPut_Data_Valid = 1'b0; bus.SD_InPut_Data_Addr = '0;
      #2 rst = 1'b0;
      step(2);
      check_reset_outputs("reset");
      rst = 1'b1;
      step(1);

      // single req0 transaction, capture at grant, status 1 cycle after SD_Complite
      set_req(1, 1'b0, 32'h100, 32'd7);
      set_req(0, 1'b1, 32'd5, 32'd1);
      g = cyc + 1;
      push(K_GRANT, 0, 32'd5, 32'd1, g);
      step(1);
      set_req(0, 1'b1, 32'd9, 32'd9);          // must be ignored until next grant
      bus.SD_Out_Data_Valid = 1'b1; bus.SD_Out_Data = 32'h1234_5678; bus.SD_Out_Data_Addr = 32'd3;
      push(K_RD, 1, 32'h1234_5678, 32'd3, cyc);
      step(1);
      bus.SD_Out_Data_Valid = 1'b0;
      step(g + 20 - cyc);
      bus.SD_Complite = 1'b1;
      push(K_DROP, 0, 32'd5, 32'd1, cyc + 1);
      push(K_DONE, 0, 32'd0, 32'd0, cyc + 1);
      step(1);
      bus.SD_Complite = 1'b0;
      step(2);
      check("release_hold_complite", {31'd0, bus.req0_Complite}, 32'd1);
      set_en(0, 1'b0);
      step(1);
      check("release_clear_complite", {31'd0, bus.req0_Complite}, 32'd0);

      // simultaneous requests after reset: req0 first, req1 next pass
      rst = 1'b0; step(1); rst = 1'b1; step(1);
      set_req(0, 1'b1, 32'h10, 32'd2);
      set_req(1, 1'b1, 32'h20, 32'd3);
      push(K_GRANT, 0, 32'h10, 32'd2, cyc + 1);
      step(5);
      finish_txn(0, 32'h10, 32'd2, K_DONE);
      push(K_GRANT, 0, 32'h20, 32'd3, cyc + 1);
      step(1);
      // write path with req1 owning
      bus.req0_InPut_Data = 32'h1111_1111; bus.req1_InPut_Data = 32'hDEAD_BEEF;
      bus.SD_InPut_Data_Valid = 1'b1; bus.SD_InPut_Data_Addr = 32'h44;
      push(K_WR, 2, 32'hDEAD_BEEF, 32'h44, cyc);
      step(1);
      bus.SD_InPut_Data_Valid = 1'b0;
      bus.SD_Out_Data_Valid = 1'b1; bus.SD_Out_Data = 32'hCAFE_F00D; bus.SD_Out_Data_Addr = 32'd7;
      push(K_RD, 2, 32'hCAFE_F00D, 32'd7, cyc);
      step(1);
      bus.SD_Out_Data_Valid = 1'b0;
      step(2);
      finish_txn(1, 32'h20, 32'd3, K_DONE);
      // strobes in IDLE stay low, SD_InPut_Data is 0
      bus.SD_Out_Data_Valid = 1'b1; bus.SD_Out_Data = 32'hA5A5_A5A5; bus.SD_Out_Data_Addr = 32'd1;
      bus.SD_InPut_Data_Valid = 1'b1; bus.SD_InPut_Data_Addr = 32'd2;
      push(K_WR, 0, 32'd0, 32'd2, cyc);
      push(K_RD, 0, 32'hA5A5_A5A5, 32'd1, cyc);
      step(1);
      bus.SD_Out_Data_Valid = 1'b0; bus.SD_InPut_Data_Valid = 1'b0;

      // fail then retry keeps req0 ahead of waiting req1
      set_req(1, 1'b1, 32'h40, 32'd5);
      set_req(0, 1'b1, 32'h30, 32'd4);
      push(K_GRANT, 0, 32'h30, 32'd4, cyc + 1);
      step(4);
      finish_txn(0, 32'h30, 32'd4, K_FAIL);
      set_en(0, 1'b1);
      push(K_GRANT, 0, 32'h30, 32'd4, cyc + 1);
      step(3);
      finish_txn(0, 32'h30, 32'd4, K_DONE);
      push(K_GRANT, 0, 32'h40, 32'd5, cyc + 1);
      step(3);
      // abort by req1: silent release
      set_en(1, 1'b0);
      push(K_DROP, 0, 32'h40, 32'd5, cyc + 1);
      step(2);

      // watchdog: exactly 100 cycles of SD_Enable, then Fail
      set_req(0, 1'b1, 32'h50, 32'd6);
      push(K_GRANT, 0, 32'h50, 32'd6, cyc + 1);
      push(K_DROP, 0, 32'h50, 32'd6, cyc + 101);
      push(K_FAIL, 0, 32'd0, 32'd0, cyc + 101);
      step(100);
      check("watchdog_enable_last_cycle", {31'd0, bus.SD_Enable}, 32'd1);
      step(1);
      set_en(0, 1'b0);
      step(1);

      // controller loses init during GRANT -> Fail
      set_req(1, 1'b1, 32'h60, 32'd8);
      push(K_GRANT, 0, 32'h60, 32'd8, cyc + 1);
      step(3);
      bus.SD_Init_Complite = 1'b0;
      push(K_DROP, 0, 32'h60, 32'd8, cyc + 1);
      push(K_FAIL, 1, 32'd0, 32'd0, cyc + 1);
      step(1);
      set_en(1, 1'b0);
      step(1);
      // no grant while controller not initialised
      set_req(0, 1'b1, 32'h70, 32'd1);
      step(5);
      check("no_grant_without_init", {31'd0, bus.SD_Enable}, 32'd0);
      bus.SD_Init_Complite = 1'b1;
      push(K_GRANT, 0, 32'h70, 32'd1, cyc + 1);
      step(3);

      // asynchronous reset mid GRANT
      push(K_DROP, 0, 32'd0, 32'd0, cyc);
      rst = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      set_en(0, 1'b0);
      step(2);
      rst = 1'b1;
      step(3);

      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL missing_%s: got nothing, required who=%0d a=%h b=%h cyc=%0d",
                  kname(e.kind), e.who, e.a, e.b, e.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
